// File: rtl/decoder38_pkg.sv
// Shared types and sizing for the sequenced 3-to-8 decoder.
package decoder38_pkg;

  localparam int CODE_W       = 3;
  localparam int OUT_W        = 8;
  localparam int CNT_W        = 4;
  localparam int HOLD_DEFAULT = 4;

  // Controller states: idle, holding one captured code, or walking all lines.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/dec38_comb.sv
// Combinational 3-bit binary to 8-bit one-hot decoder with enable.
module dec38_comb
  import decoder38_pkg::*;
(
  input  logic              en_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [OUT_W-1:0]  onehot_o
);

  // Disabled decoder drives all-zero so the output is always 0 or one-hot.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[code_i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder38_seq.sv
// Sequenced 3-to-8 decoder: holds one decoded line for HOLD cycles, or scans
// all eight lines in order while scan is held. o is registered, so a request
// sampled at one edge shows on o in the following cycle.
module decoder38_seq
  import decoder38_pkg::*;
#(
  parameter int HOLD = HOLD_DEFAULT
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  input  logic              scan,
  output logic [OUT_W-1:0]  o,
  output logic              busy,
  output logic              done
);

  // The counter counts down from HOLD-1, so a line lasts exactly HOLD cycles.
  localparam logic [CNT_W-1:0]  RELOAD    = CNT_W'(HOLD - 1);
  localparam logic [CODE_W-1:0] LAST_STEP = '1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   step_q, step_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                done_q, done_d;
  logic [OUT_W-1:0]    o_q;

  logic                dec_en;
  logic [CODE_W-1:0]   dec_code;
  logic [OUT_W-1:0]    dec_o;

  // Next-state logic; the decoder is fed from next-state values so o lines up
  // with the state it describes once registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    code_d  = code_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan) begin
          state_d = ST_SCAN;
          step_d  = '0;
          cnt_d   = RELOAD;
        end else if (en) begin
          state_d = ST_HOLD;
          code_d  = code;
          cnt_d   = RELOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SCAN: begin
        if (!scan) begin
          // Abort: back to idle without a completion pulse.
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + CODE_W'(1);
            cnt_d  = RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    dec_en   = (state_d != ST_IDLE);
    dec_code = (state_d == ST_SCAN) ? step_d : code_d;
  end

  dec38_comb u_dec (
    .en_i     (dec_en),
    .code_i   (dec_code),
    .onehot_o (dec_o)
  );

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      code_q  <= code_d;
      done_q  <= done_d;
      o_q     <= dec_o;
    end
  end

  assign o    = o_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decoder38_seq.sv
// Bench for decoder38_seq: three instances (HOLD=4, 2, 1) share stimulus;
// each check names the instance whose outputs it compares.
module tb_decoder38_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] code;
  logic       scan;

  logic [7:0] o4, o2, o1;
  logic       busy4, busy2, busy1;
  logic       done4, done2, done1;

  decoder38_seq #(.HOLD(4)) u_h4 (.clk(clk), .rst_n(rst_n), .en(en), .code(code),
    .scan(scan), .o(o4), .busy(busy4), .done(done4));
  decoder38_seq #(.HOLD(2)) u_h2 (.clk(clk), .rst_n(rst_n), .en(en), .code(code),
    .scan(scan), .o(o2), .busy(busy2), .done(done2));
  decoder38_seq #(.HOLD(1)) u_h1 (.clk(clk), .rst_n(rst_n), .en(en), .code(code),
    .scan(scan), .o(o1), .busy(busy1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o;
    logic       busy;
    logic       done;
    int         sel;   // 0: HOLD=4, 1: HOLD=2, 2: HOLD=1
    int         rt;    // expected encoder round trip, -1 to skip
  } exp_t;

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_o;
  } vec_t;

  exp_t  sbq[$];
  vec_t  tbl[8];
  int    nvec;
  int    nerr;
  string tname;

  function automatic int enc83(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] ov, input logic b, input logic d,
                      input int sel, input int rt, input int n);
    exp_t e;
    e.o = ov; e.busy = b; e.done = d; e.sel = sel; e.rt = rt;
    repeat (n) sbq.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [7:0] ao;
    logic ab, ad;
    e = sbq.pop_front();
    case (e.sel)
      0:       begin ao = o4; ab = busy4; ad = done4; end
      1:       begin ao = o2; ab = busy2; ad = done2; end
      default: begin ao = o1; ab = busy1; ad = done1; end
    endcase
    nvec++;
    if (ao !== e.o) begin
      nerr++;
      $display("FAIL %s[%0d] o: got %h want %h", tname, nvec, ao, e.o);
    end
    if (ab !== e.busy) begin
      nerr++;
      $display("FAIL %s[%0d] busy: got %b want %b", tname, nvec, ab, e.busy);
    end
    if (ad !== e.done) begin
      nerr++;
      $display("FAIL %s[%0d] done: got %b want %b", tname, nvec, ad, e.done);
    end
    if ($isunknown(ao) || !$onehot0(ao)) begin
      nerr++;
      $display("FAIL %s[%0d] onehot: got %h want zero or one-hot", tname, nvec, ao);
    end
    if (e.rt >= 0 && enc83(ao) != e.rt) begin
      nerr++;
      $display("FAIL %s[%0d] roundtrip: got %0d want %0d", tname, nvec, enc83(ao), e.rt);
    end
  endtask

  // Compare queued expectations cycle by cycle; ends in the last checked cycle.
  task automatic drain();
    while (sbq.size() > 0) begin
      chk();
      if (sbq.size() > 0) tick();
    end
  endtask

  // Called just after a rising edge: pulse reset and release between edges.
  task automatic do_reset();
    en = 1'b0; scan = 1'b0; code = 3'd0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    tbl[0] = '{3'd0, 8'h01}; tbl[1] = '{3'd1, 8'h02};
    tbl[2] = '{3'd2, 8'h04}; tbl[3] = '{3'd3, 8'h08};
    tbl[4] = '{3'd4, 8'h10}; tbl[5] = '{3'd5, 8'h20};
    tbl[6] = '{3'd6, 8'h40}; tbl[7] = '{3'd7, 8'h80};

    // Reset state before any clock edge, on all instances.
    tname = "reset";
    en = 1'b0; scan = 1'b0; code = 3'd0;
    rst_n = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) push(8'h00, 1'b0, 1'b0, s, -1, 1);
    drain();
    rst_n = 1'b1;
    tick();
    push(8'h00, 1'b0, 1'b0, 0, -1, 1);
    drain();

    // Back-to-back decode, HOLD=1, en held high, every code.
    do_reset();
    tname = "b2b_table";
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      code = tbl[i].code;
      tick();
      push(tbl[i].exp_o, 1'b1, 1'b0, 2, int'(tbl[i].code), 1);
      push(8'h00, 1'b0, 1'b1, 2, -1, 1);
      drain();
    end
    en = 1'b0;
    tick();
    push(8'h00, 1'b0, 1'b0, 2, -1, 1);
    drain();

    // Single decode, HOLD=4, code 5.
    do_reset();
    tname = "single";
    en = 1'b1; code = 3'd5;
    tick();
    en = 1'b0;
    push(8'h20, 1'b1, 1'b0, 0, 5, 4);
    push(8'h00, 1'b0, 1'b1, 0, -1, 1);
    push(8'h00, 1'b0, 1'b0, 0, -1, 1);
    drain();

    // New request and code change while busy are ignored.
    do_reset();
    tname = "ignored";
    en = 1'b1; code = 3'd2;
    tick();
    en = 1'b0;
    push(8'h04, 1'b1, 1'b0, 0, 2, 1);
    drain();
    en = 1'b1; code = 3'd6;
    tick();
    en = 1'b0;
    push(8'h04, 1'b1, 1'b0, 0, 2, 3);
    push(8'h00, 1'b0, 1'b1, 0, -1, 1);
    push(8'h00, 1'b0, 1'b0, 0, -1, 2);
    drain();

    // Full scan, HOLD=2: 16 line cycles then one done cycle.
    do_reset();
    tname = "scan_h2";
    scan = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) push(8'(1 << s), 1'b1, 1'b0, 1, s, 2);
    push(8'h00, 1'b0, 1'b1, 1, -1, 1);
    drain();
    scan = 1'b0;
    tick();
    push(8'h00, 1'b0, 1'b0, 1, -1, 1);
    drain();

    // Full scan, HOLD=1: 8 line cycles then one done cycle.
    do_reset();
    tname = "scan_h1";
    scan = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) push(8'(1 << s), 1'b1, 1'b0, 2, s, 1);
    push(8'h00, 1'b0, 1'b1, 2, -1, 1);
    drain();
    scan = 1'b0;
    tick();
    push(8'h00, 1'b0, 1'b0, 2, -1, 1);
    drain();

    // Scan abort during step 3.
    do_reset();
    tname = "scan_abort";
    scan = 1'b1;
    tick();
    push(8'h01, 1'b1, 1'b0, 1, 0, 2);
    push(8'h02, 1'b1, 1'b0, 1, 1, 2);
    push(8'h04, 1'b1, 1'b0, 1, 2, 2);
    push(8'h08, 1'b1, 1'b0, 1, 3, 1);
    drain();
    scan = 1'b0;
    tick();
    push(8'h00, 1'b0, 1'b0, 1, -1, 2);
    drain();

    // Asynchronous reset mid-HOLD, code 7; no done afterwards, then a new request.
    do_reset();
    tname = "async_rst";
    en = 1'b1; code = 3'd7;
    tick();
    en = 1'b0;
    push(8'h80, 1'b1, 1'b0, 0, 7, 2);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    push(8'h00, 1'b0, 1'b0, 0, -1, 1);
    drain();
    #2;
    rst_n = 1'b1;
    tick();
    push(8'h00, 1'b0, 1'b0, 0, -1, 5);
    drain();
    en = 1'b1; code = 3'd3;
    tick();
    en = 1'b0;
    push(8'h08, 1'b1, 1'b0, 0, 3, 4);
    push(8'h00, 1'b0, 1'b1, 0, -1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
